// File: rtl/lcd_text_buffer.sv
// Two-row character buffer for an HD44780-style LCD. Accepts a byte stream
// over a valid/ready handshake, interprets printable characters and a small
// set of control codes, and exposes the 32 cells through a combinational
// read port that the LCD driver scans.
module lcd_text_buffer #(
  parameter logic [7:0] BLANK  = 8'h20,
  parameter int         N_COLS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ch_data,
  input  logic       ch_valid,
  output logic       ch_ready,
  input  logic [4:0] mem_addr,
  output logic [7:0] mem_bus,
  output logic [4:0] cursor,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, CLEAR, SCROLL} state_t;

  localparam logic [3:0] LAST_COL = 4'(N_COLS - 1);

  state_t     state_q;
  logic [4:0] seq_cnt_q;
  logic [4:0] cursor_q;
  logic [7:0] cell_q [32];

  logic       accept;
  logic       is_print, is_lf, is_cr, is_bs, is_ff;
  logic       cur_row;
  logic [3:0] cur_col;

  // Write port A serves character writes, backspace, clear and the scroll copy;
  // port B only blanks the bottom row during a scroll.
  logic       wa_en_d;
  logic [4:0] wa_addr_d;
  logic [7:0] wa_data_d;
  logic       wb_en_d;
  logic [4:0] wb_addr_d;

  assign accept   = ch_valid && (state_q == IDLE);
  assign is_print = ((ch_data >= 8'h20) && (ch_data <= 8'h7E)) || (ch_data >= 8'hA0);
  assign is_lf    = (ch_data == 8'h0A);
  assign is_cr    = (ch_data == 8'h0D);
  assign is_bs    = (ch_data == 8'h08);
  assign is_ff    = (ch_data == 8'h0C);
  assign cur_row  = cursor_q[4];
  assign cur_col  = cursor_q[3:0];

  // Select which cells change this cycle, based on state and accepted input.
  always_comb begin
    wa_en_d   = 1'b0;
    wa_addr_d = cursor_q;
    wa_data_d = ch_data;
    wb_en_d   = 1'b0;
    wb_addr_d = {1'b1, seq_cnt_q[3:0]};
    case (state_q)
      IDLE: begin
        if (accept && is_print) begin
          wa_en_d = 1'b1;
        end else if (accept && is_bs && (cur_col != 4'd0)) begin
          wa_en_d   = 1'b1;
          wa_addr_d = {cur_row, cur_col - 4'd1};
          wa_data_d = BLANK;
        end
      end
      CLEAR: begin
        wa_en_d   = 1'b1;
        wa_addr_d = seq_cnt_q;
        wa_data_d = BLANK;
      end
      SCROLL: begin
        wa_en_d   = 1'b1;
        wa_addr_d = {1'b0, seq_cnt_q[3:0]};
        wa_data_d = cell_q[{1'b1, seq_cnt_q[3:0]}];
        wb_en_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // One register per cell so reset can blank the whole buffer at once.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_cell
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cell_q[gi] <= BLANK;
        end else if (wa_en_d && (wa_addr_d == 5'(gi))) begin
          cell_q[gi] <= wa_data_d;
        end else if (wb_en_d && (wb_addr_d == 5'(gi))) begin
          cell_q[gi] <= BLANK;
        end
      end
    end
  endgenerate

  // Control FSM: cursor movement, and the counter-driven clear/scroll sequences.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      seq_cnt_q <= 5'd0;
      cursor_q  <= 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_print) begin
              if (cur_col != LAST_COL) begin
                cursor_q <= {cur_row, cur_col + 4'd1};
              end else if (!cur_row) begin
                cursor_q <= 5'd16;
              end else begin
                // Bottom-right cell was just written; scroll it up to row 0.
                state_q   <= SCROLL;
                seq_cnt_q <= 5'd0;
                cursor_q  <= 5'd16;
              end
            end else if (is_lf) begin
              cursor_q <= 5'd16;
              if (cur_row) begin
                state_q   <= SCROLL;
                seq_cnt_q <= 5'd0;
              end
            end else if (is_cr) begin
              cursor_q <= {cur_row, 4'd0};
            end else if (is_bs) begin
              if (cur_col != 4'd0) begin
                cursor_q <= {cur_row, cur_col - 4'd1};
              end
            end else if (is_ff) begin
              state_q   <= CLEAR;
              seq_cnt_q <= 5'd0;
              cursor_q  <= 5'd0;
            end
          end
        end
        CLEAR: begin
          if (seq_cnt_q == 5'd31) begin
            state_q   <= IDLE;
            seq_cnt_q <= 5'd0;
          end else begin
            seq_cnt_q <= seq_cnt_q + 5'd1;
          end
        end
        SCROLL: begin
          if (seq_cnt_q == 5'd15) begin
            state_q   <= IDLE;
            seq_cnt_q <= 5'd0;
          end else begin
            seq_cnt_q <= seq_cnt_q + 5'd1;
          end
        end
        default: begin
          state_q   <= IDLE;
          seq_cnt_q <= 5'd0;
        end
      endcase
    end
  end

  assign ch_ready = (state_q == IDLE);
  assign busy     = ~ch_ready;
  assign cursor   = cursor_q;
  assign mem_bus  = cell_q[mem_addr];

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Self-checking bench for lcd_text_buffer: directed scenarios plus a random
// byte stream checked against a screen model kept as a plain array.
module tb_lcd_text_buffer;

  localparam logic [7:0] BL = 8'h20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ch_data;
  logic       ch_valid;
  logic       ch_ready;
  logic [4:0] mem_addr;
  logic [7:0] mem_bus;
  logic [4:0] cursor;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Screen model: 32 cells, linear cursor 0..31, expected busy length of last op.
  logic [7:0] m_mem [32];
  int         m_cur;
  int         m_busy;

  lcd_text_buffer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ch_data  (ch_data),
    .ch_valid (ch_valid),
    .ch_ready (ch_ready),
    .mem_addr (mem_addr),
    .mem_bus  (mem_bus),
    .cursor   (cursor),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = BL;
    m_cur = 0;
  endfunction

  function automatic void model_scroll();
    for (int i = 0; i < 16; i++) begin
      m_mem[i]      = m_mem[i + 16];
      m_mem[i + 16] = BL;
    end
  endfunction

  // Applies one accepted byte to the model; returns the expected busy length.
  function automatic int model_apply(input logic [7:0] c);
    int ret = 0;
    if (((c >= 8'h20) && (c <= 8'h7E)) || (c >= 8'hA0)) begin
      m_mem[m_cur] = c;
      if (m_cur == 31) begin
        model_scroll();
        m_cur = 16;
        ret   = 16;
      end else begin
        m_cur = m_cur + 1;
      end
    end else if (c == 8'h0A) begin
      if (m_cur >= 16) begin
        model_scroll();
        ret = 16;
      end
      m_cur = 16;
    end else if (c == 8'h0D) begin
      m_cur = (m_cur / 16) * 16;
    end else if (c == 8'h08) begin
      if ((m_cur % 16) != 0) begin
        m_cur        = m_cur - 1;
        m_mem[m_cur] = BL;
      end
    end else if (c == 8'h0C) begin
      for (int i = 0; i < 32; i++) m_mem[i] = BL;
      m_cur = 0;
      ret   = 32;
    end
    return ret;
  endfunction

  task automatic do_reset();
    ch_valid = 1'b0;
    ch_data  = 8'h00;
    mem_addr = 5'd0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Offer one byte and complete the handshake (bounded wait for ready).
  task automatic put(input logic [7:0] c);
    int w = 0;
    @(negedge clk);
    ch_data  = c;
    ch_valid = 1'b1;
    while (!ch_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!ch_ready) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout data=%02h ready=%b required=1", c, ch_ready);
    end
    @(posedge clk);
    #1;
    ch_valid = 1'b0;
    m_busy   = model_apply(c);
  endtask

  // Count negedges with busy high; returns at a negedge with busy low.
  task automatic busy_len(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] c, output int n);
    put(c);
    busy_len(n);
    $display("tx data=%02h cursor=%0d busy_cycles=%0d", c, cursor, n);
  endtask

  task automatic read_cell(input int a, output logic [7:0] v);
    mem_addr = a[4:0];
    #1;
    v = mem_bus;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    do_reset();
    #1;
    checks++;
    if (ch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ch_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (cursor !== 5'd0) begin errors++; $display("FAIL reset_cursor got=%0d exp=0", cursor); end
    for (int i = 0; i < 32; i++) begin
      read_cell(i, v);
      checks++;
      if (v !== BL) begin errors++; $display("FAIL reset_cell%0d got=%02h exp=%02h", i, v, BL); end
    end
  endtask

  task automatic test_hi();
    int n0, n1;
    logic [7:0] v;
    do_reset();
    send(8'h48, n0);
    send(8'h49, n1);
    checks++;
    if (n0 != 0 || n1 != 0) begin errors++; $display("FAIL hi_ready_drop got=%0d/%0d exp=0/0", n0, n1); end
    read_cell(0, v);
    checks++;
    if (v !== 8'h48) begin errors++; $display("FAIL hi_cell0 got=%02h exp=48", v); end
    read_cell(1, v);
    checks++;
    if (v !== 8'h49) begin errors++; $display("FAIL hi_cell1 got=%02h exp=49", v); end
    checks++;
    if (cursor !== 5'd2) begin errors++; $display("FAIL hi_cursor got=%0d exp=2", cursor); end
  endtask

  task automatic test_wrap();
    int n;
    logic [7:0] v;
    do_reset();
    for (int i = 0; i < 16; i++) send(8'h41, n);
    send(8'h42, n);
    for (int i = 0; i < 16; i++) begin
      read_cell(i, v);
      checks++;
      if (v !== 8'h41) begin errors++; $display("FAIL wrap_cell%0d got=%02h exp=41", i, v); end
    end
    read_cell(16, v);
    checks++;
    if (v !== 8'h42) begin errors++; $display("FAIL wrap_cell16 got=%02h exp=42", v); end
    checks++;
    if (cursor !== 5'd17) begin errors++; $display("FAIL wrap_cursor got=%0d exp=17", cursor); end
  endtask

  // Fill 31 cells, then LF from row 1 scrolls; cell 31 was never written.
  task automatic test_scroll_lf();
    int n;
    logic [7:0] v, e;
    do_reset();
    for (int i = 0; i < 31; i++) send(8'h30 + 8'(i % 10), n);
    send(8'h0A, n);
    checks++;
    if (n != 16) begin errors++; $display("FAIL scroll_lf_busy got=%0d exp=16", n); end
    for (int i = 0; i < 32; i++) begin
      e = (i < 15) ? 8'h30 + 8'((i + 16) % 10) : BL;
      read_cell(i, v);
      checks++;
      if (v !== e) begin errors++; $display("FAIL scroll_lf_cell%0d got=%02h exp=%02h", i, v, e); end
    end
    checks++;
    if (cursor !== 5'd16) begin errors++; $display("FAIL scroll_lf_cursor got=%0d exp=16", cursor); end
  endtask

  // The 32nd printable lands in cell 31 and is carried up to cell 15.
  task automatic test_scroll_char();
    int n;
    logic [7:0] v, e;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      send(8'h30 + 8'(i % 10), n);
      checks++;
      if (n != ((i == 31) ? 16 : 0)) begin
        errors++;
        $display("FAIL scroll_char_busy i=%0d got=%0d exp=%0d", i, n, (i == 31) ? 16 : 0);
      end
    end
    for (int i = 0; i < 32; i++) begin
      e = (i < 16) ? 8'h30 + 8'((i + 16) % 10) : BL;
      read_cell(i, v);
      checks++;
      if (v !== e) begin errors++; $display("FAIL scroll_char_cell%0d got=%02h exp=%02h", i, v, e); end
    end
    checks++;
    if (cursor !== 5'd16) begin errors++; $display("FAIL scroll_char_cursor got=%0d exp=16", cursor); end
  endtask

  // FF with the next byte held valid throughout the clear.
  task automatic test_clear();
    int n;
    logic [7:0] v;
    do_reset();
    for (int i = 0; i < 3; i++) send(8'h61, n);
    send(8'h58, n);
    put(8'h0C);
    ch_data  = 8'h5A;
    ch_valid = 1'b1;
    busy_len(n);
    checks++;
    if (n != 32) begin errors++; $display("FAIL clear_busy got=%0d exp=32", n); end
    checks++;
    if (cursor !== 5'd0) begin errors++; $display("FAIL clear_cursor got=%0d exp=0", cursor); end
    read_cell(3, v);
    checks++;
    if (v !== BL) begin errors++; $display("FAIL clear_cell3 got=%02h exp=%02h", v, BL); end
    read_cell(0, v);
    checks++;
    if (v !== BL) begin errors++; $display("FAIL clear_early_accept got=%02h exp=%02h", v, BL); end
    @(posedge clk);
    #1;
    ch_valid = 1'b0;
    m_busy   = model_apply(8'h5A);
    @(negedge clk);
    read_cell(0, v);
    checks++;
    if (v !== 8'h5A) begin errors++; $display("FAIL clear_held_byte got=%02h exp=5a", v); end
    checks++;
    if (cursor !== 5'd1) begin errors++; $display("FAIL clear_held_cursor got=%0d exp=1", cursor); end
  endtask

  task automatic test_ctrl();
    int n;
    logic [7:0] v;
    do_reset();
    for (int i = 0; i < 5; i++) send(8'h78, n);
    send(8'h08, n);
    checks++;
    if (cursor !== 5'd4) begin errors++; $display("FAIL bs_cursor got=%0d exp=4", cursor); end
    read_cell(4, v);
    checks++;
    if (v !== BL) begin errors++; $display("FAIL bs_cell4 got=%02h exp=%02h", v, BL); end
    send(8'h0A, n);
    send(8'h08, n);
    checks++;
    if (cursor !== 5'd16) begin errors++; $display("FAIL bs_col0 got=%0d exp=16", cursor); end
    for (int i = 0; i < 4; i++) send(8'h79, n);
    send(8'h0D, n);
    checks++;
    if (cursor !== 5'd16) begin errors++; $display("FAIL cr_cursor got=%0d exp=16", cursor); end
    send(8'h07, n);
    checks++;
    if (cursor !== 5'd16 || n != 0) begin errors++; $display("FAIL bel_nop cursor=%0d busy=%0d exp=16/0", cursor, n); end
    for (int i = 0; i < 32; i++) begin
      read_cell(i, v);
      checks++;
      if (v !== m_mem[i]) begin errors++; $display("FAIL ctrl_cell%0d got=%02h exp=%02h", i, v, m_mem[i]); end
    end
  endtask

  task automatic test_reset_mid_scroll();
    int n;
    logic [7:0] v;
    do_reset();
    for (int i = 0; i < 31; i++) send(8'h41 + 8'(i % 26), n);
    put(8'h0A);
    repeat (7) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_scroll_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (cursor !== 5'd0 || ch_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset cursor=%0d ready=%b exp=0/1", cursor, ch_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    checks++;
    if (ch_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_ready ready=%b busy=%b exp=1/0", ch_ready, busy);
    end
    for (int i = 0; i < 32; i++) begin
      read_cell(i, v);
      checks++;
      if (v !== BL) begin errors++; $display("FAIL abort_cell%0d got=%02h exp=%02h", i, v, BL); end
    end
  endtask

  task automatic test_random();
    int n, r;
    logic [7:0] c, v;
    do_reset();
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      c = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(32, 126)) : 8'($urandom_range(160, 255));
      else if (r < 80) c = 8'h0A;
      else if (r < 85) c = 8'h0D;
      else if (r < 92) c = 8'h08;
      else if (r < 94) c = 8'h0C;
      else             c = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(127, 159));
      send(c, n);
      checks++;
      if (n != m_busy) begin errors++; $display("FAIL rand_busy k=%0d data=%02h got=%0d exp=%0d", k, c, n, m_busy); end
      checks++;
      if (cursor !== 5'(m_cur)) begin errors++; $display("FAIL rand_cursor k=%0d data=%02h got=%0d exp=%0d", k, c, cursor, m_cur); end
      if ((k % 8) == 7) begin
        for (int i = 0; i < 32; i++) begin
          read_cell(i, v);
          checks++;
          if (v !== m_mem[i]) begin errors++; $display("FAIL rand_cell%0d k=%0d got=%02h exp=%02h", i, k, v, m_mem[i]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_hi();
    test_wrap();
    test_scroll_lf();
    test_scroll_char();
    test_clear();
    test_ctrl();
    test_reset_mid_scroll();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_text_buffer.md
LCD_TEXT_BUFFER -- requirements
Module: lcd_text_buffer

Interface
REQ-001 The block SHALL have parameter BLANK, default 8'h20, as the fill character written on reset, clear, scroll and backspace.
REQ-002 The block SHALL have parameter N_COLS, default 16, as the characters per row; two rows fixed, 32 cells total.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the reset: asynchronous, active-low.
REQ-005 Port ch_data, input, 8, SHALL carry the character or control code offered by the producer.
REQ-006 Port ch_valid, input, 1, SHALL indicate ch_data is valid.
REQ-007 Port ch_ready, output, 1, SHALL indicate the block accepts ch_data this cycle; transfer occurs when ch_valid and ch_ready are both high at a rising edge.
REQ-008 Port mem_addr, input, 5, SHALL be the display read address {row, col[3:0]} driven by the LCD driver.
REQ-009 Port mem_bus, output, 8, SHALL be the cell contents at mem_addr.
REQ-010 Port cursor, output, 5, SHALL be the current write position {row, col}.
REQ-011 Port busy, output, 1, SHALL be high while a clear or scroll sequence runs.

Function
REQ-012 Storage SHALL be 32 x 8-bit registers; mem_bus SHALL be a combinational read of cell[mem_addr], no added latency.
REQ-013 FSM states SHALL be IDLE, CLEAR, SCROLL; ch_ready = (state == IDLE); busy = ~ch_ready.
REQ-014 A character accepted at edge N SHALL be visible on mem_bus (same address) and the updated cursor SHALL be valid after edge N.
REQ-015 Printable codes (8'h20-8'h7E, 8'hA0-8'hFF) SHALL be written to cell[cursor], then the cursor advances.
REQ-016 Advance: col<15 -> col+1; row0 col15 -> row1 col0; row1 col15 -> enter SCROLL, cursor row1 col0 on exit.
REQ-017 8'h0A (LF): row0 -> row1 col0; row1 -> enter SCROLL, cursor row1 col0 on exit.
REQ-018 8'h0D (CR) SHALL set col to 0 and keep row; no cell written.
REQ-019 8'h08 (BS): col>0 -> col-1 and that cell := BLANK; col=0 -> no effect (no row wrap).
REQ-020 8'h0C (FF) SHALL enter CLEAR; cursor := 0 on exit.
REQ-021 All other codes SHALL be accepted and discarded with no state change.
REQ-022 CLEAR SHALL last exactly 32 cycles, writing BLANK to cell i (i = 0..31 ascending) in cycle i, then return to IDLE.
REQ-023 SCROLL SHALL last exactly 16 cycles; in cycle i (0..15): cell[i] := cell[16+i], cell[16+i] := BLANK; then IDLE.
REQ-024 The printable char that triggers SCROLL at row1 col15 SHALL be written to cell 31 before the scroll, so it ends in cell 15.
REQ-025 A single 5-bit sequence counter SHALL be shared by CLEAR and SCROLL; cleared on entry.
REQ-026 mem_bus MAY show partially updated content during CLEAR/SCROLL; reads SHALL never return X.
REQ-027 ch_valid while ch_ready is low SHALL cause no state change; producer holds ch_data.

Reset
REQ-028 rst_n low SHALL immediately set all 32 cells to BLANK, cursor to 0, state to IDLE, counter to 0.
REQ-029 After rst_n deasserts: ch_ready = 1, busy = 0, mem_bus = BLANK for every address.
REQ-030 Reset asserted mid-CLEAR or mid-SCROLL SHALL abort the sequence with the REQ-028 result.

Verification
REQ-031 Reset then send "HI" (8'h48, 8'h49) -> cell0 = 8'h48, cell1 = 8'h49, cursor = 5'd2, ch_ready continuously high.
REQ-032 Send 16 x 8'h41 then 8'h42 -> cells 0-15 = 8'h41, cell16 = 8'h42, cursor = 5'd17.
REQ-033 Fill all 32 cells with 8'h30 + (i mod 10), then 8'h0A -> ch_ready low exactly 16 cycles; after: cells 0-15 = old cells 16-31, cells 16-31 = 8'h20, cursor = 5'd16.
REQ-034 Send 8'h0C after writing 8'h58 to cell 3 -> busy high exactly 32 cycles, then all cells 8'h20, cursor 0; ch_valid held high during busy not accepted until ch_ready returns.
REQ-035 Cursor at 5'd5: 8'h08 -> cursor 5'd4, cell4 = 8'h20; cursor at 5'd16: 8'h08 -> no change; 8'h0D at 5'd20 -> cursor 5'd16; 8'h07 -> no change.
REQ-036 Assert rst_n low in SCROLL cycle 7 -> all cells 8'h20, cursor 0, ch_ready 1 after release.
